// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - byte-serial line refill engine feeding the instruction cache fill port
module icache_refill #(
  parameter int ADDR_WIDTH  = 17,
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                          clkIn,
  input  logic                          resetIn,
  input  logic                          missIn,
  input  logic [ADDR_WIDTH-1:0]         missAddrIn,
  input  logic                          flushIn,
  input  logic [7:0]                    ramDataIn,
  output logic                          ramReqOut,
  output logic [ADDR_WIDTH-1:0]         ramAddrOut,
  output logic                          busy,
  output logic                          memDataValid,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memAddr,
  output logic [BLOCK_SIZE*8-1:0]       memDataOut
);

  localparam int BLK_W  = ADDR_WIDTH - BLOCK_WIDTH;
  localparam int LINE_W = BLOCK_SIZE * 8;

  localparam logic [BLOCK_WIDTH:0]   ISSUE_ONE = {{BLOCK_WIDTH{1'b0}}, 1'b1};
  localparam logic [BLOCK_WIDTH-1:0] RECV_ONE  = {{(BLOCK_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                   state_q, state_d;
  logic [BLK_W-1:0]         blk_q, blk_d;
  logic [BLOCK_WIDTH:0]     issue_cnt_q, issue_cnt_d;
  logic [BLOCK_WIDTH-1:0]   recv_cnt_q, recv_cnt_d;
  logic                     req_dly_q, req_dly_d;
  logic [LINE_W-9:0]        line_q, line_d;
  logic [BLK_W-1:0]         last_blk_q, last_blk_d;
  logic                     last_valid_q, last_valid_d;
  logic                     ram_req_q, ram_req_d;
  logic [ADDR_WIDTH-1:0]    ram_addr_q, ram_addr_d;
  logic                     busy_q, busy_d;
  logic                     mem_valid_q, mem_valid_d;
  logic [BLK_W-1:0]         mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]        mem_data_q, mem_data_d;

  logic [BLK_W-1:0]         miss_blk;
  logic                     unused_lo;

  // Only the block number of the missing address matters; the byte offset is refetched anyway.
  assign miss_blk  = missAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH];
  assign unused_lo = ^missAddrIn[BLOCK_WIDTH-1:0];

  // State and output registers; reset drops any partial line without strobing the cache.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_q      <= IDLE;
      blk_q        <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      req_dly_q    <= 1'b0;
      line_q       <= '0;
      last_blk_q   <= '0;
      last_valid_q <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_addr_q   <= '0;
      busy_q       <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      req_dly_q    <= req_dly_d;
      line_q       <= line_d;
      last_blk_q   <= last_blk_d;
      last_valid_q <= last_valid_d;
      ram_req_q    <= ram_req_d;
      ram_addr_q   <= ram_addr_d;
      busy_q       <= busy_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // Next-state logic: issue side runs one cycle ahead, receive side trails the RAM by two cycles.
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    req_dly_d    = ram_req_q;
    line_d       = line_q;
    last_blk_d   = last_blk_q;
    last_valid_d = last_valid_q;
    ram_req_d    = ram_req_q;
    ram_addr_d   = ram_addr_q;
    busy_d       = busy_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;

    case (state_q)
      IDLE: begin
        // A miss on the line just written is the cache's stale registered flag, not a real miss.
        if (missIn && !flushIn && !(last_valid_q && (miss_blk == last_blk_q))) begin
          blk_d       = miss_blk;
          ram_req_d   = 1'b1;
          ram_addr_d  = {miss_blk, {BLOCK_WIDTH{1'b0}}};
          busy_d      = 1'b1;
          issue_cnt_d = ISSUE_ONE;
          recv_cnt_d  = '0;
          state_d     = FETCH;
        end
      end

      FETCH: begin
        if (flushIn) begin
          ram_req_d   = 1'b0;
          ram_addr_d  = '0;
          busy_d      = 1'b0;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          if (!issue_cnt_q[BLOCK_WIDTH]) begin
            ram_req_d   = 1'b1;
            ram_addr_d  = {blk_q, issue_cnt_q[BLOCK_WIDTH-1:0]};
            issue_cnt_d = issue_cnt_q + ISSUE_ONE;
          end else begin
            ram_req_d  = 1'b0;
            ram_addr_d = '0;
          end

          // req_dly_q marks a cycle whose ramDataIn answers a request from two edges earlier.
          if (req_dly_q) begin
            if (&recv_cnt_q) begin
              mem_data_d   = {ramDataIn, line_q};
              mem_addr_d   = blk_q;
              mem_valid_d  = 1'b1;
              last_blk_d   = blk_q;
              last_valid_d = 1'b1;
              state_d      = DONE;
            end else begin
              for (int k = 0; k < BLOCK_SIZE - 1; k++) begin
                if (recv_cnt_q == BLOCK_WIDTH'(k)) begin
                  line_d[8*k +: 8] = ramDataIn;
                end
              end
              recv_cnt_d = recv_cnt_q + RECV_ONE;
            end
          end
        end
      end

      DONE: begin
        mem_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ramReqOut    = ram_req_q;
  assign ramAddrOut   = ram_addr_q;
  assign busy         = busy_q;
  assign memDataValid = mem_valid_q;
  assign memAddr      = mem_addr_q;
  assign memDataOut   = mem_data_q;

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed self-checking bench for icache_refill
module tb_icache_refill;

  logic         clkIn = 1'b0;
  logic         resetIn;
  logic         missIn;
  logic [16:0]  missAddrIn;
  logic         flushIn;
  logic [7:0]   ram_q = 8'h00;
  logic         ramReqOut;
  logic [16:0]  ramAddrOut;
  logic         busy;
  logic         memDataValid;
  logic [12:0]  memAddr;
  logic [127:0] memDataOut;

  int errors = 0;
  int checks = 0;
  int cyc;
  int reqs;
  bit seen;

  localparam logic [127:0] L12   = 128'h2F2E2D2C_2B2A2928_27262524_23222120;
  localparam logic [127:0] L1004 = 128'h4F4E4D4C_4B4A4948_47464544_43424140;
  localparam logic [127:0] L00   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  icache_refill dut (
    .clkIn        (clkIn),
    .resetIn      (resetIn),
    .missIn       (missIn),
    .missAddrIn   (missAddrIn),
    .flushIn      (flushIn),
    .ramDataIn    (ram_q),
    .ramReqOut    (ramReqOut),
    .ramAddrOut   (ramAddrOut),
    .busy         (busy),
    .memDataValid (memDataValid),
    .memAddr      (memAddr),
    .memDataOut   (memDataOut)
  );

  always #5 clkIn = ~clkIn;

  // One-cycle-latency RAM returning the low byte of the sampled address.
  always @(posedge clkIn) begin
    if (ramReqOut) ram_q <= ramAddrOut[7:0];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   128'(ramReqOut),    128'(0));
    check({tag, "_addr"},  128'(ramAddrOut),   128'(0));
    check({tag, "_busy"},  128'(busy),         128'(0));
    check({tag, "_valid"}, 128'(memDataValid), 128'(0));
    check({tag, "_maddr"}, 128'(memAddr),      128'(0));
    check({tag, "_mdata"}, memDataOut,         128'(0));
  endtask

  // Called in the cycle after acceptance; stops in the strobe cycle or after a bounded wait.
  task automatic run_to_strobe(output int cycles, output int nreq);
    cycles = 0;
    nreq   = int'(ramReqOut);
    while (cycles < 30 && memDataValid !== 1'b1) begin
      tick();
      cycles++;
      nreq += int'(ramReqOut);
    end
  endtask

  initial begin
    resetIn = 1'b1; missIn = 1'b0; flushIn = 1'b0; missAddrIn = '0;
    tick(); tick();
    check_all_zero("reset");
    resetIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_req", 128'(ramReqOut), 128'(0));
    end

    // Basic refill of block 0x0012
    missIn = 1'b1; missAddrIn = 17'h00124;
    tick();
    check("t2_busy", 128'(busy), 128'(1));
    for (int k = 0; k < 16; k++) begin
      check("t2_req",   128'(ramReqOut),    128'(1));
      check("t2_addr",  128'(ramAddrOut),   128'(17'h00120 + 17'(k)));
      check("t2_novld", 128'(memDataValid), 128'(0));
      if (k < 15) tick();
    end
    tick();
    check("t2_req_off",  128'(ramReqOut),  128'(0));
    check("t2_addr_off", 128'(ramAddrOut), 128'(0));
    tick();
    check("t2_strobe",   128'(memDataValid), 128'(1));
    check("t2_maddr",    128'(memAddr),      128'(13'h0012));
    check("t2_mdata",    memDataOut,         L12);
    check("t2_busy_str", 128'(busy),         128'(1));
    tick();
    check("t2_strobe_off", 128'(memDataValid), 128'(0));
    check("t2_busy_off",   128'(busy),         128'(0));

    // Stale miss on the block just filled is suppressed
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_stale_req", 128'(ramReqOut), 128'(0));
    end
    check("t3_hold", memDataOut, L12);
    missAddrIn = 17'h10040;
    tick();
    check("t3_req",  128'(ramReqOut),  128'(1));
    check("t3_addr", 128'(ramAddrOut), 128'(17'h10040));
    run_to_strobe(cyc, reqs);
    check("t3_strobe",  128'(memDataValid), 128'(1));
    check("t3_latency", 128'(cyc),          128'(17));
    check("t3_nreq",    128'(reqs),         128'(16));
    check("t3_maddr",   128'(memAddr),      128'(13'h1004));
    check("t3_mdata",   memDataOut,         L1004);
    missIn = 1'b0;

    // Flush in the 8th FETCH cycle
    tick();
    missIn = 1'b1; missAddrIn = 17'h00200;
    tick();
    missIn = 1'b0;
    check("t4_addr0", 128'(ramAddrOut), 128'(17'h00200));
    repeat (7) tick();
    check("t4_addr7", 128'(ramAddrOut), 128'(17'h00207));
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    check("t4_flush_req",  128'(ramReqOut),  128'(0));
    check("t4_flush_busy", 128'(busy),       128'(0));
    check("t4_flush_addr", 128'(ramAddrOut), 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (memDataValid) seen = 1'b1;
    end
    check("t4_no_strobe", 128'(seen), 128'(0));
    missIn = 1'b1; missAddrIn = 17'h10040;
    tick(); tick();
    check("t4_last_kept", 128'(ramReqOut), 128'(0));
    missAddrIn = 17'h00200;
    tick();
    check("t4_refetch_req",  128'(ramReqOut),  128'(1));
    check("t4_refetch_addr", 128'(ramAddrOut), 128'(17'h00200));
    missIn = 1'b0;
    run_to_strobe(cyc, reqs);
    check("t4_strobe",  128'(memDataValid), 128'(1));
    check("t4_latency", 128'(cyc),          128'(17));
    check("t4_nreq",    128'(reqs),         128'(16));
    check("t4_maddr",   128'(memAddr),      128'(13'h0020));
    check("t4_mdata",   memDataOut,         L00);

    // Flush beats miss in IDLE, flush beats completion
    flushIn = 1'b1; missIn = 1'b1; missAddrIn = 17'h00500;
    tick(); tick();
    check("t5_idle_req",  128'(ramReqOut), 128'(0));
    check("t5_idle_busy", 128'(busy),      128'(0));
    flushIn = 1'b0;
    tick();
    check("t5_acc", 128'(ramReqOut), 128'(1));
    missIn = 1'b0;
    repeat (16) tick();
    check("t5_pre", 128'(memDataValid), 128'(0));
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    check("t5_no_strobe", 128'(memDataValid), 128'(0));
    check("t5_busy",      128'(busy),         128'(0));
    check("t5_maddr_hold", 128'(memAddr),     128'(13'h0020));
    check("t5_mdata_hold", memDataOut,        L00);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (memDataValid) seen = 1'b1;
    end
    check("t5_no_late_strobe", 128'(seen), 128'(0));
    missIn = 1'b1; missAddrIn = 17'h00200;
    tick(); tick();
    check("t5_last_kept", 128'(ramReqOut), 128'(0));
    missAddrIn = 17'h00500;
    tick();
    check("t5_req",  128'(ramReqOut),  128'(1));
    check("t5_addr", 128'(ramAddrOut), 128'(17'h00500));
    missIn = 1'b0;
    run_to_strobe(cyc, reqs);
    check("t5_strobe", 128'(memDataValid), 128'(1));
    check("t5_maddr",  128'(memAddr),      128'(13'h0050));
    check("t5_mdata",  memDataOut,         L00);

    // Reset mid-refill
    tick();
    missIn = 1'b1; missAddrIn = 17'h00300;
    tick();
    missIn = 1'b0;
    check("t6_addr0", 128'(ramAddrOut), 128'(17'h00300));
    repeat (11) tick();
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    check_all_zero("t6_reset");
    missIn = 1'b1; missAddrIn = 17'h00500;
    tick();
    check("t6_last_clr_req",  128'(ramReqOut),  128'(1));
    check("t6_last_clr_addr", 128'(ramAddrOut), 128'(17'h00500));
    missIn = 1'b0; flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    check("t6_flush_req", 128'(ramReqOut), 128'(0));
    missIn = 1'b1; missAddrIn = 17'h00300;
    tick();
    check("t6_req",  128'(ramReqOut),  128'(1));
    check("t6_addr", 128'(ramAddrOut), 128'(17'h00300));
    missIn = 1'b0;
    run_to_strobe(cyc, reqs);
    check("t6_strobe",  128'(memDataValid), 128'(1));
    check("t6_latency", 128'(cyc),          128'(17));
    check("t6_nreq",    128'(reqs),         128'(16));
    check("t6_maddr",   128'(memAddr),      128'(13'h0030));
    check("t6_mdata",   memDataOut,         L00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
